// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Result is registered 10 cycles after the load edge together with a one-cycle valid pulse.
module aes_top (
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
);

   typedef enum logic {IDLE, BUSY} fsm_e;

   // NOTE: the S-box is a constant table feeding combinational lookups, so it has no reset.
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [127:0] out_q, out_d;
   logic         valid_q, valid_d;

   logic [31:0]  t_word;
   logic [127:0] key_next, sub_b, shift_r, mix_c, round_out;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      key_d   = key_q;
      out_d   = out_q;
      valid_d = 1'b0;

      // t = SubWord(RotWord(w3)) ^ Rcon
      t_word = {sbox(key_q[23:16]), sbox(key_q[15:8]), sbox(key_q[7:0]), sbox(key_q[31:24])}
               ^ {rcon(round_q), 24'h0};
      key_next[127:96] = key_q[127:96] ^ t_word;
      key_next[95:64]  = key_q[95:64]  ^ key_next[127:96];
      key_next[63:32]  = key_q[63:32]  ^ key_next[95:64];
      key_next[31:0]   = key_q[31:0]   ^ key_next[63:32];

      for (int i = 0; i < 16; i++)
         sub_b[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
      // Byte 4c+r is row r of column c; row r rotates left by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shift_r[127-8*(4*c+r) -: 8] = sub_b[127-8*(4*((c+r)%4)+r) -: 8];
      for (int c = 0; c < 4; c++)
         mix_c[127-32*c -: 32] = mix_col(shift_r[127-32*c -: 32]);
      round_out = ((round_q == 4'd10) ? shift_r : mix_c) ^ key_next;

      case (fsm_q)
         IDLE: begin
            if (AES_en) begin
               state_d = AES_data_in ^ AES_key_in;
               key_d   = AES_key_in;
               round_d = 4'd1;
               fsm_d   = BUSY;
            end
         end
         BUSY: begin
            state_d = round_out;
            key_d   = key_next;
            if (round_q == 4'd10) begin
               out_d   = round_out;
               valid_d = 1'b1;
               round_d = 4'd0;
               fsm_d   = IDLE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge AES_clk) begin
      if (!AES_rst_n) begin
         fsm_q   <= IDLE;
         round_q <= 4'd0;
         state_q <= '0;
         key_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
         key_q   <= key_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign AES_data_out       = out_q;
   assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_top.sv
// Directed bench for aes_top: known-answer vectors, a cycle-accurate scoreboard of expected
// completions, and per-cycle checks of the valid pulse and the held output.
module tb_aes_top;

   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } exp_t;

   logic         AES_clk;
   logic         AES_rst_n;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;

   exp_t         sb[$];
   int           cyc;
   int           done_cyc;
   logic [127:0] model_out;
   logic         exp_v;
   int           n_checks;
   int           n_errors;

   aes_top dut (
      .AES_clk            (AES_clk),
      .AES_rst_n          (AES_rst_n),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid)
   );

   initial AES_clk = 1'b0;
   always #5 AES_clk = ~AES_clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Known-answer table; an unknown pair yields X so its data check cannot pass.
   function automatic logic [127:0] ref_ct(input logic [127:0] key, input logic [127:0] pt);
      if (key == K_C1 && pt == P_C1) return C_C1;
      if (key == K_B  && pt == P_B)  return C_B;
      if (key == '0   && pt == '0)   return C_Z;
      return 'x;
   endfunction

   // One cycle: wait for the falling edge, account for what the preceding rising edge sampled,
   // then compare the DUT outputs against the scoreboard.
   task automatic tick();
      @(negedge AES_clk);
      cyc++;
      if (!AES_rst_n) begin
         sb.delete();
         model_out = '0;
         done_cyc  = cyc;
      end else if (cyc > done_cyc && AES_en) begin
         sb.push_back('{ct: ref_ct(AES_key_in, AES_data_in), cyc: cyc + 10});
         done_cyc = cyc + 10;
      end
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("valid", {127'b0, AES_data_out_valid}, {127'b0, exp_v});
      if (exp_v) begin
         model_out = sb[0].ct;
         void'(sb.pop_front());
      end
      check("data_out", AES_data_out, model_out);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((sb.size() > 0 || cyc <= done_cyc) && k < budget) begin
         tick();
         k++;
      end
      check("drain_timeout", {127'b0, (sb.size() == 0)}, 128'd1);
      tick();
      tick();
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      done_cyc  = 0;
      model_out = '0;

      // Reset held two cycles with a start request pending; start fires right after release.
      AES_rst_n   = 1'b0;
      AES_en      = 1'b1;
      AES_key_in  = K_C1;
      AES_data_in = P_C1;
      tick();
      tick();
      AES_rst_n = 1'b1;
      tick();
      AES_en = 1'b0;
      drain(30);

      // FIPS-197 appendix B vector, then all-zero key and plaintext.
      AES_key_in  = K_B;
      AES_data_in = P_B;
      AES_en      = 1'b1;
      tick();
      AES_en = 1'b0;
      drain(30);
      AES_key_in  = '0;
      AES_data_in = '0;
      AES_en      = 1'b1;
      tick();
      AES_en = 1'b0;
      drain(30);

      // Inputs scrambled while busy must not disturb the captured block.
      AES_key_in  = K_C1;
      AES_data_in = P_C1;
      AES_en      = 1'b1;
      tick();
      AES_en = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
         AES_data_in = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      drain(30);

      // Start held high: back-to-back blocks every 11 cycles, none after it falls.
      AES_key_in  = K_B;
      AES_data_in = P_B;
      AES_en      = 1'b1;
      repeat (50) tick();
      AES_en = 1'b0;
      drain(30);
      repeat (12) tick();

      // Reset pulse at round 5 aborts the block; a fresh start then completes normally.
      AES_key_in  = K_C1;
      AES_data_in = P_C1;
      AES_en      = 1'b1;
      tick();
      AES_en = 1'b0;
      repeat (4) tick();
      AES_rst_n = 1'b0;
      tick();
      AES_rst_n = 1'b1;
      repeat (15) tick();
      AES_en = 1'b1;
      tick();
      AES_en = 1'b0;
      drain(30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
